// File: rtl/aes_state_serializer.sv
// aes_state_serializer: streams a 4x4 AES state as OUT_W-bit beats under valid/ready
// Ports: clk, reset (sync, active-high); in_state[row][col]/in_valid/in_ready input
// handshake; out_data/out_valid/out_ready/out_last beat stream; busy while a state is held.
module aes_state_serializer #(
  parameter int OUT_W     = 8,
  parameter bit ROW_MAJOR = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:3][0:3][7:0]  in_state,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);
  localparam int BEATS = 128 / OUT_W;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  if ((OUT_W < 1) || (128 % OUT_W != 0)) begin : g_bad_width
    $error("aes_state_serializer: OUT_W must divide 128");
  end
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0] hold_q, hold_d;
  logic [127:0] lin;
  logic [127:0] sh;
  logic in_xfer, out_xfer;
  always_comb begin
    lin = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        lin[127 - 8*(ROW_MAJOR ? r*4 + c : c*4 + r) -: 8] = in_state[r][c];
  end
  always_comb begin
    out_valid = state_q == SEND;
    busy      = state_q == SEND;
    out_last  = (state_q == SEND) && (cnt_q == LAST);
    // out_ready feeds in_ready combinationally so a new state lands on the last beat's edge
    in_ready  = (state_q == IDLE) || (out_last && out_ready);
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
    sh        = hold_q << (cnt_q * OUT_W);
    out_data  = out_valid ? sh[127 -: OUT_W] : '0;
    state_d   = in_xfer ? SEND : (out_xfer && out_last) ? IDLE : state_q;
    cnt_d     = (in_xfer || (out_xfer && out_last)) ? '0 : out_xfer ? cnt_q + 1'b1 : cnt_q;
    hold_d    = in_xfer ? lin : hold_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_aes_state_serializer.sv
// tb_aes_state_serializer: four widths/orders in parallel against a beat-queue reference model
module tb_aes_state_serializer;
  logic clk = 1'b0;
  logic reset;
  logic [0:3][0:3][7:0] in_state;
  logic in_valid, out_ready;
  logic [127:0] od0;
  logic [31:0] od1;
  logic [7:0] od2;
  logic [15:0] od3;
  logic [127:0] od[4];
  logic ir[4], ov[4], ol[4], bz[4];
  int checks = 0;
  int errors = 0;
  logic [127:0] ml[4];
  int mpos[4];
  bit mact[4];

  always #5 clk = ~clk;

  aes_state_serializer #(.OUT_W(128), .ROW_MAJOR(1'b0)) u0 (.clk(clk), .reset(reset), .in_state(in_state),
    .in_valid(in_valid), .in_ready(ir[0]), .out_data(od0), .out_valid(ov[0]), .out_ready(out_ready),
    .out_last(ol[0]), .busy(bz[0]));
  aes_state_serializer #(.OUT_W(32), .ROW_MAJOR(1'b1)) u1 (.clk(clk), .reset(reset), .in_state(in_state),
    .in_valid(in_valid), .in_ready(ir[1]), .out_data(od1), .out_valid(ov[1]), .out_ready(out_ready),
    .out_last(ol[1]), .busy(bz[1]));
  aes_state_serializer #(.OUT_W(8), .ROW_MAJOR(1'b0)) u2 (.clk(clk), .reset(reset), .in_state(in_state),
    .in_valid(in_valid), .in_ready(ir[2]), .out_data(od2), .out_valid(ov[2]), .out_ready(out_ready),
    .out_last(ol[2]), .busy(bz[2]));
  aes_state_serializer #(.OUT_W(16), .ROW_MAJOR(1'b0)) u3 (.clk(clk), .reset(reset), .in_state(in_state),
    .in_valid(in_valid), .in_ready(ir[3]), .out_data(od3), .out_valid(ov[3]), .out_ready(out_ready),
    .out_last(ol[3]), .busy(bz[3]));

  always_comb begin
    od[0] = od0;
    od[1] = {96'b0, od1};
    od[2] = {120'b0, od2};
    od[3] = {112'b0, od3};
  end

  function automatic int wof(input int i);
    return i == 0 ? 128 : i == 1 ? 32 : i == 2 ? 8 : 16;
  endfunction

  function automatic logic [127:0] lin(input logic [0:3][0:3][7:0] s, input bit rm);
    logic [127:0] l = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int k = rm ? r*4 + c : c*4 + r;
        l[127 - 8*k -: 8] = s[r][c];
      end
    return l;
  endfunction

  function automatic logic [127:0] mbeat(input int i);
    return (ml[i] << (mpos[i] * wof(i))) >> (128 - wof(i));
  endfunction

  function automatic bit mlast(input int i);
    return mact[i] && (mpos[i] == 128 / wof(i) - 1);
  endfunction

  function automatic bit mrdy(input int i);
    return !mact[i] || (mlast(i) && out_ready);
  endfunction

  task automatic chk(input string tag, input int i, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d] got %h expected %h", tag, i, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("out_valid", i, {127'b0, ov[i]}, {127'b0, mact[i]});
      chk("busy", i, {127'b0, bz[i]}, {127'b0, mact[i]});
      chk("in_ready", i, {127'b0, ir[i]}, {127'b0, mrdy(i)});
      if (mact[i]) begin
        chk("out_data", i, od[i], mbeat(i));
        chk("out_last", i, {127'b0, ol[i]}, {127'b0, mlast(i)});
      end
    end
  endtask

  task automatic tick();
    bit rdy[4];
    @(posedge clk);
    for (int i = 0; i < 4; i++) rdy[i] = mrdy(i);
    for (int i = 0; i < 4; i++) begin
      if (reset) mact[i] = 1'b0;
      else begin
        if (mact[i] && out_ready) begin
          if (mlast(i)) mact[i] = 1'b0;
          else mpos[i]++;
        end
        if (in_valid && rdy[i]) begin
          ml[i] = lin(in_state, i == 1);
          mpos[i] = 0;
          mact[i] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic rand_state();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) in_state[r][c] = 8'($urandom);
  endtask

  initial begin
    logic [31:0] e2[4];
    logic [127:0] e1;
    e2 = '{32'h328831e0, 32'h435a3137, 32'hf6309807, 32'ha88da234};
    e1 = 128'h3243f6a8885a308d313198a2e0370734;
    for (int i = 0; i < 4; i++) begin mact[i] = 1'b0; mpos[i] = 0; ml[i] = '0; end
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    tick(); tick();
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", i, {127'b0, ov[i]}, 128'd0);
      chk("rst_ready", i, {127'b0, ir[i]}, 128'd1);
      chk("rst_data", i, od[i], 128'd0);
      chk("rst_last", i, {127'b0, ol[i]}, 128'd0);
    end
    // known-answer state, full-rate drain
    in_state = '{'{8'h32, 8'h88, 8'h31, 8'he0}, '{8'h43, 8'h5a, 8'h31, 8'h37},
                 '{8'hf6, 8'h30, 8'h98, 8'h07}, '{8'ha8, 8'h8d, 8'ha2, 8'h34}};
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) begin
        chk("kat128_data", 0, od[0], e1);
        chk("kat128_last", 0, {127'b0, ol[0]}, 128'd1);
      end
      chk("kat32_data", 1, od[1], {96'b0, e2[k]});
      chk("kat32_last", 1, {127'b0, ol[1]}, {127'b0, k == 3});
      chk("kat8_data", 2, od[2], {120'b0, e1[127 - 8*k -: 8]});
      tick();
    end
    // stall on alternate cycles while the input state churns
    for (int k = 0; k < 40; k++) begin
      out_ready = k[0];
      rand_state();
      step();
      tick();
    end
    // back-to-back states A and B with in_valid held high
    reset = 1'b1; tick(); reset = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; rand_state();
    tick();
    rand_state();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("b2b_ready", 3, {127'b0, ir[3]}, {127'b0, k == 7});
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin rand_state(); step(); tick(); end
    // reset in the middle of a stream
    in_valid = 1'b1; rand_state(); tick(); in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin step(); tick(); end
    reset = 1'b1; tick(); reset = 1'b0;
    step();
    chk("mid_rst_valid", 2, {127'b0, ov[2]}, 128'd0);
    chk("mid_rst_ready", 2, {127'b0, ir[2]}, 128'd1);
    chk("mid_rst_busy", 2, {127'b0, bz[2]}, 128'd0);
    chk("mid_rst_data", 2, od[2], 128'd0);
    in_valid = 1'b1; rand_state(); tick(); in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin step(); tick(); end
    // random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 63) == 0;
      rand_state();
      step();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
